// File: rtl/ysyx_22041461_srl_seq.sv
// Multi-cycle logical-right-shift sequencer: shifts at most STEP bits per cycle.
// Optional perf counters (perf_ops, perf_busy) are built when YSYX_22041461_SRL_SEQ_PERF_EN is defined.
module ysyx_22041461_srl_seq #(
  parameter int STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  input  logic [4:0]  ctrl_ALU,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        busy
`ifdef YSYX_22041461_SRL_SEQ_PERF_EN
  ,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_busy
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
  typedef enum logic [1:0] {K_SRL, K_SEXT, K_ILL} kind_e;

  localparam logic [6:0] STEP_AMT = 7'(STEP);

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic [63:0] data_q, data_d;
  logic [5:0]  amt_q, amt_d;
  logic [63:0] result_q, result_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;

  kind_e       acc_kind;
  logic [63:0] acc_data;
  logic [5:0]  acc_amt;
  logic [6:0]  step_amt;
  logic [6:0]  amt_left;
  logic [63:0] shifted;

  // Only the low six bits of the shift-amount source matter.
  logic unused_src2;
  assign unused_src2 = ^src2[63:6];

  function automatic logic [63:0] fmt_result(input logic [63:0] d, input kind_e k);
    case (k)
      K_SRL:   return d;
      K_SEXT:  return {{32{d[31]}}, d[31:0]};
      default: return 64'd0;
    endcase
  endfunction

  always_comb begin
    acc_kind = K_ILL;
    acc_data = 64'd0;
    acc_amt  = 6'd0;
    case (ctrl_ALU)
      5'b01011: begin
        acc_kind = K_SRL;
        acc_data = src1;
        acc_amt  = src2[5:0];
      end
      5'b11101: begin
        acc_kind = K_SEXT;
        acc_data = src1;
        acc_amt  = src2[5:0];
      end
      5'b11110: begin
        acc_kind = K_SEXT;
        acc_data = {32'd0, src1[31:0]};
        acc_amt  = {1'b0, src2[4:0]};
      end
      default: begin
        acc_kind = K_ILL;
        acc_data = 64'd0;
        acc_amt  = 6'd0;
      end
    endcase
  end

  always_comb begin
    step_amt = ({1'b0, amt_q} < STEP_AMT) ? {1'b0, amt_q} : STEP_AMT;
    amt_left = {1'b0, amt_q} - step_amt;
    shifted  = data_q >> step_amt;

    state_d  = state_q;
    kind_d   = kind_q;
    data_d   = data_q;
    amt_d    = amt_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          kind_d = acc_kind;
          data_d = acc_data;
          amt_d  = acc_amt;
          if (acc_amt == 6'd0) begin
            result_d = fmt_result(acc_data, acc_kind);
            state_d  = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        data_d = shifted;
        amt_d  = amt_left[5:0];
        if (amt_left == 7'd0) begin
          result_d = fmt_result(shifted, kind_q);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush aborts everything in flight but leaves the last result visible.
    if (flush) begin
      state_d  = S_IDLE;
      kind_d   = K_SRL;
      data_d   = 64'd0;
      amt_d    = 6'd0;
      result_d = result_q;
    end

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      kind_q      <= K_SRL;
      data_q      <= 64'd0;
      amt_q       <= 6'd0;
      result_q    <= 64'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      data_q      <= data_d;
      amt_q       <= amt_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;

`ifdef YSYX_22041461_SRL_SEQ_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_busy_q, perf_busy_d;

  // A handshake that coincides with flush is dropped, so it is not counted.
  always_comb begin
    perf_ops_d  = perf_ops_q;
    perf_busy_d = perf_busy_q;
    if (out_valid_q && out_ready && !flush && (perf_ops_q != 32'hFFFF_FFFF))
      perf_ops_d = perf_ops_q + 32'd1;
    if (busy_q && (perf_busy_q != 32'hFFFF_FFFF))
      perf_busy_d = perf_busy_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_q  <= 32'd0;
      perf_busy_q <= 32'd0;
    end else begin
      perf_ops_q  <= perf_ops_d;
      perf_busy_q <= perf_busy_d;
    end
  end

  assign perf_ops  = perf_ops_q;
  assign perf_busy = perf_busy_q;
`endif

endmodule

// File: doc/ysyx_22041461_srl_seq.md
Name: ysyx_22041461_srl_seq

Overview:
- Multi-cycle sequencer for the logical-right-shift datapath. Shifts by at most STEP bit positions per cycle instead of using a full 64-bit barrel shifter.
- Accepts one shift op from EXU with a valid/ready handshake, iterates, and returns a registered result with a valid/ready handshake.
- ctrl_ALU encodings and result semantics are identical to the single-cycle SRL unit, so the two can be swapped in the ALU.

Parameters:
- STEP, 8, max shift distance applied per SHIFT cycle; power of two, 1..64.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous abort of any in-flight op (pipeline flush)
- in_valid  in  1  request valid
- in_ready  out  1  sequencer can accept (state==IDLE)
- src1  in  64  shift operand
- src2  in  64  shift amount source
- ctrl_ALU  in  5  op: 5'b01011 SRL, 5'b11101 SRL-then-sext32, 5'b11110 SRLW
- out_valid  out  1  result valid (state==DONE)
- out_ready  in  1  consumer accepts result
- result  out  64  registered result
- busy  out  1  state!=IDLE

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, internal data/count=0.
- Priority: rst > flush > normal operation.
- States: IDLE, SHIFT, DONE.
- IDLE: accept on in_valid&in_ready. Latch the operation as follows:
  - 01011 / 11101: data=src1, amt=src2[5:0].
  - 11110: data={32'd0,src1[31:0]}, amt={1'b0,src2[4:0]}.
  - Any other ctrl_ALU: illegal; data=0, amt=0.
  - Then go to SHIFT if amt!=0, else DONE.
- SHIFT: each cycle, s=min(amt,STEP); data>>=s (zero fill); amt-=s. When the new amt==0, load result and go to DONE.
- Result load:
  - 01011: result=data.
  - 11101/11110: result={{32{data[31]}},data[31:0]}.
  - Illegal op: result=0.
  - amt==0 case: result is loaded at the accepting edge with the same rules.
- DONE: out_valid=1; result held stable until out_valid&out_ready. Then go to IDLE. in_ready rises the cycle after the output handshake; there is no same-cycle back-to-back.
- Latency: out_valid rises 1+ceil(amt/STEP) cycles after the accepting edge (1 for amt==0 or illegal).
- in_valid while not IDLE is ignored. The source must hold its request until in_ready.
- flush in any state:
  - Next state IDLE, out_valid=0, data/amt cleared; result keeps its last value.
  - A flush coincident with the output handshake drops the op; no retry.
  - A flush coincident with in_valid in IDLE suppresses the accept.
- rst mid-operation: returns to full reset values next cycle.
- Inputs are not required to be stable after acceptance.

Optional Feature:
- Macro YSYX_22041461_SRL_SEQ_PERF_EN.
- Defined:
  - Adds output perf_ops[31:0], a count of completed output handshakes, saturating at 0xFFFF_FFFF.
  - Adds output perf_busy[31:0], a count of cycles with busy=1, saturating.
  - Both counters clear on rst only; flush does not clear them.
- Undefined: both ports and their counters are absent. Functional behaviour is identical in both builds.

Test Plan:
- STEP=8, op 01011, src1=0x8000_0000_0000_0000, src2=63 -> result=0x0000_0000_0000_0001; out_valid rises 9 cycles after accept; exactly 8 SHIFT cycles.
- Op 11110, src1=0xFFFF_FFFF_8000_0000, src2=0x20 (amt 0) -> result=0xFFFF_FFFF_8000_0000, latency 1. Then src2=0x1F -> result=0x0000_0000_0000_0001, latency 5.
- Op 11101, src1=0x0000_0001_0000_0000, src2=1 -> result=0xFFFF_FFFF_8000_0000, latency 2. Op 5'b00000, src1=all-ones -> result=0, latency 1.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid=1 and result stable; in_ready=0; new in_valid ignored. out_ready=1 -> in_ready=1 next cycle.
- flush asserted during the 3rd SHIFT cycle of a 63-bit shift -> IDLE next cycle, out_valid never rises. A following op 01011, src1=0xF0, src2=4 -> result=0x0F.
- rst asserted in SHIFT and in DONE -> all outputs at reset values next cycle. With PERF_EN: 3 completed ops give perf_ops=3; a flushed op is not counted.
